// File: rtl/bus_source_decoder.sv
// bus_source_decoder: sequenced 5-to-32 one-hot bus-source driver with hold and turnaround; define BUS_DEC_INVALID_TRAP_EN to trap codes >= 24
module bus_source_decoder #(
  parameter int HOLD_CYCLES = 1,
  parameter int TURNAROUND = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req,
  input  logic [4:0]  src_code,
  output logic [31:0] sel_out,
  output logic        busy,
  output logic        ack,
  output logic [4:0]  active_code,
  output logic        err
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, TURN = 2'd2;
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] TURN_LD = 4'(TURNAROUND - 1);
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_hold_chk
    $error("HOLD_CYCLES must be 1..15");
  end
  if (TURNAROUND < 0 || TURNAROUND > 7) begin : g_turn_chk
    $error("TURNAROUND must be 0..7");
  end
  logic [1:0] state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] code_n;
  logic       err_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    code_n = active_code;
    err_n = err;
    if (state == IDLE) begin
      if (req) begin
        code_n = src_code;
`ifdef BUS_DEC_INVALID_TRAP_EN
        err_n = src_code >= 5'd24;
        state_n = err_n ? (TURNAROUND > 0 ? TURN : IDLE) : DRIVE;
        cnt_n = err_n ? (TURNAROUND > 0 ? TURN_LD : 4'd0) : HOLD_LD;
`else
        state_n = DRIVE;
        cnt_n = HOLD_LD;
`endif
      end
    end else if (cnt != 4'd0) begin
      cnt_n = cnt - 4'd1;
    end else if (state == DRIVE && TURNAROUND > 0) begin
      state_n = TURN;
      cnt_n = TURN_LD;
    end else begin
      state_n = IDLE;
      cnt_n = 4'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      cnt <= 4'd0;
      active_code <= 5'd0;
      err <= 1'b0;
      sel_out <= 32'd0;
      busy <= 1'b0;
      ack <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      active_code <= code_n;
      err <= err_n;
      sel_out <= (state_n == DRIVE && code_n < 5'd24) ? 32'd1 << code_n : 32'd0;
      busy <= state_n != IDLE;
      ack <= state_n == DRIVE && cnt_n == 4'd0;
    end
  end
endmodule

// File: tb/tb_bus_source_decoder.sv
// tb_bus_source_decoder: scoreboard bench over three parameterisations (1/1, 2/1, 4/0)
module tb_bus_source_decoder;
  typedef struct packed {
    logic [31:0] sel;
    logic        ack;
    logic        busy;
    logic        err;
  } exp_t;
  logic        clk = 1'b0;
  logic        clr = 1'b0, clr4 = 1'b0;
  logic        req1 = 1'b0, req2 = 1'b0, req4 = 1'b0;
  logic [4:0]  code = 5'd0;
  logic [31:0] sel1, sel2, sel4;
  logic        busy1, busy2, busy4, ack1, ack2, ack4, err1, err2, err4;
  logic [4:0]  ac1, ac2, ac4;
  exp_t        q[$];
  exp_t        e;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  bus_source_decoder #(.HOLD_CYCLES(1), .TURNAROUND(1)) u1 (
    .clk(clk), .clr(clr), .req(req1), .src_code(code), .sel_out(sel1),
    .busy(busy1), .ack(ack1), .active_code(ac1), .err(err1));
  bus_source_decoder #(.HOLD_CYCLES(2), .TURNAROUND(1)) u2 (
    .clk(clk), .clr(clr), .req(req2), .src_code(code), .sel_out(sel2),
    .busy(busy2), .ack(ack2), .active_code(ac2), .err(err2));
  bus_source_decoder #(.HOLD_CYCLES(4), .TURNAROUND(0)) u4 (
    .clk(clk), .clr(clr4), .req(req4), .src_code(code), .sel_out(sel4),
    .busy(busy4), .ack(ack4), .active_code(ac4), .err(err4));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] s, input logic a, input logic b, input logic r);
    q.push_back('{sel: s, ack: a, busy: b, err: r});
  endtask
  task automatic test_reset();
    clr = 1'b0;
    clr4 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({sel1, busy1, ack1, err1, ac1} !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_u1: got sel=%h busy=%b ack=%b err=%b code=%0d want all 0", sel1, busy1, ack1, err1, ac1);
    end
    n_cmp++;
    if ({sel2, busy2, ack2, err2, ac2} !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_u2: got sel=%h busy=%b ack=%b err=%b want all 0", sel2, busy2, ack2, err2);
    end
    n_cmp++;
    if ({sel4, busy4, ack4, err4, ac4} !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_u4: got sel=%h busy=%b ack=%b err=%b want all 0", sel4, busy4, ack4, err4);
    end
    clr = 1'b1;
    clr4 = 1'b1;
    tick();
  endtask
  task automatic test_single();
    code = 5'd20;
    req1 = 1'b1;
    push(32'h0010_0000, 1'b1, 1'b1, 1'b0);
    push(32'd0, 1'b0, 1'b1, 1'b0);
    push(32'd0, 1'b0, 1'b0, 1'b0);
    while (q.size() > 0) begin
      tick();
      req1 = 1'b0;
      e = q.pop_front();
      n_cmp++;
      if ({sel1, ack1, busy1} !== {e.sel, e.ack, e.busy}) begin
        n_bad++;
        $display("FAIL single: got sel=%h ack=%b busy=%b want sel=%h ack=%b busy=%b", sel1, ack1, busy1, e.sel, e.ack, e.busy);
      end
    end
    n_cmp++;
    if (ac1 !== 5'd20) begin
      n_bad++;
      $display("FAIL single_code: got %0d want 20", ac1);
    end
  endtask
  task automatic test_sweep();
    int acks;
    for (int c = 0; c < 24; c++) begin
      code = 5'(c);
      req2 = 1'b1;
      acks = 0;
      push(32'd1 << c, 1'b0, 1'b1, 1'b0);
      push(32'd1 << c, 1'b1, 1'b1, 1'b0);
      push(32'd0, 1'b0, 1'b1, 1'b0);
      push(32'd0, 1'b0, 1'b0, 1'b0);
      while (q.size() > 0) begin
        tick();
        req2 = 1'b0;
        e = q.pop_front();
        acks += int'(ack2);
        n_cmp++;
        if ({sel2, ack2, busy2} !== {e.sel, e.ack, e.busy} || $countones(sel2) > 1) begin
          n_bad++;
          $display("FAIL sweep code %0d: got sel=%h ack=%b busy=%b want sel=%h ack=%b busy=%b", c, sel2, ack2, busy2, e.sel, e.ack, e.busy);
        end
      end
      n_cmp++;
      if (acks != 1) begin
        n_bad++;
        $display("FAIL sweep_ack code %0d: got %0d acks want 1", c, acks);
      end
    end
  endtask
  task automatic test_busy_ignore();
    int i = 0;
    code = 5'd5;
    req4 = 1'b1;
    for (int k = 0; k < 4; k++) push(32'h20, k == 3, 1'b1, 1'b0);
    push(32'd0, 1'b0, 1'b0, 1'b0);
    push(32'd0, 1'b0, 1'b0, 1'b0);
    while (q.size() > 0) begin
      tick();
      e = q.pop_front();
      n_cmp++;
      if ({sel4, ack4, busy4, ac4} !== {e.sel, e.ack, e.busy, 5'd5}) begin
        n_bad++;
        $display("FAIL busy_ignore cyc %0d: got sel=%h ack=%b busy=%b code=%0d want sel=%h ack=%b busy=%b code=5", i, sel4, ack4, busy4, ac4, e.sel, e.ack, e.busy);
      end
      req4 = (i == 1);
      code = (i >= 1) ? 5'd9 : 5'd5;
      i++;
    end
  endtask
  task automatic test_back_to_back();
    int i = 0;
    code = 5'd7;
    req4 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(32'h80, k == 3, 1'b1, 1'b0);
      push(32'd0, 1'b0, 1'b0, 1'b0);
    end
    while (q.size() > 0) begin
      tick();
      e = q.pop_front();
      n_cmp++;
      if ({sel4, ack4, busy4} !== {e.sel, e.ack, e.busy}) begin
        n_bad++;
        $display("FAIL back_to_back cyc %0d: got sel=%h ack=%b busy=%b want sel=%h ack=%b busy=%b", i, sel4, ack4, busy4, e.sel, e.ack, e.busy);
      end
      if (i == 5) req4 = 1'b0;
      i++;
    end
  endtask
  task automatic test_reset_mid();
    int i = 0;
    code = 5'd16;
    req4 = 1'b1;
    push(32'h1_0000, 1'b0, 1'b1, 1'b0);
    push(32'h1_0000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) push(32'd0, 1'b0, 1'b0, 1'b0);
    while (q.size() > 0) begin
      tick();
      e = q.pop_front();
      n_cmp++;
      if ({sel4, ack4, busy4} !== {e.sel, e.ack, e.busy}) begin
        n_bad++;
        $display("FAIL reset_mid cyc %0d: got sel=%h ack=%b busy=%b want sel=%h ack=%b busy=%b", i, sel4, ack4, busy4, e.sel, e.ack, e.busy);
      end
      if (i == 2) begin
        n_cmp++;
        if (ac4 !== 5'd0) begin
          n_bad++;
          $display("FAIL reset_mid_code: got %0d want 0", ac4);
        end
      end
      req4 = 1'b0;
      clr4 = (i != 1);
      i++;
    end
  endtask
  task automatic test_invalid();
    int i = 0;
    code = 5'd27;
    req1 = 1'b1;
`ifdef BUS_DEC_INVALID_TRAP_EN
    push(32'd0, 1'b0, 1'b1, 1'b1);
    push(32'd0, 1'b0, 1'b0, 1'b1);
`else
    push(32'd0, 1'b1, 1'b1, 1'b0);
    push(32'd0, 1'b0, 1'b1, 1'b0);
    push(32'd0, 1'b0, 1'b0, 1'b0);
`endif
    push(32'h8, 1'b1, 1'b1, 1'b0);
    push(32'd0, 1'b0, 1'b1, 1'b0);
    push(32'd0, 1'b0, 1'b0, 1'b0);
    while (q.size() > 0) begin
      tick();
      e = q.pop_front();
      n_cmp++;
      if ({sel1, ack1, busy1, err1} !== {e.sel, e.ack, e.busy, e.err}) begin
        n_bad++;
        $display("FAIL invalid cyc %0d: got sel=%h ack=%b busy=%b err=%b want sel=%h ack=%b busy=%b err=%b", i, sel1, ack1, busy1, err1, e.sel, e.ack, e.busy, e.err);
      end
      if (i == 0) begin
        n_cmp++;
        if (ac1 !== 5'd27) begin
          n_bad++;
          $display("FAIL invalid_code: got %0d want 27", ac1);
        end
      end
`ifdef BUS_DEC_INVALID_TRAP_EN
      req1 = (i == 1);
`else
      req1 = (i == 2);
`endif
      code = 5'd3;
      i++;
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_invalid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
